// File: rtl/dp_ctrl_pkg.sv
// Shared types for the dot-product job controller: FSM state encoding and
// job completion status codes.
package dp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ABORT   = 2'b10;

endpackage

// File: rtl/dp_watchdog.sv
// Per-element engine watchdog: counts enabled cycles since the last clear and
// flags expiry on the TIMEOUT-th enabled cycle.
module dp_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Expiry includes the current enabled cycle, so exactly TIMEOUT cycles elapse.
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dp_job_controller.sv
// Job sequencer for the dot-product datapath: per element it reads both
// operands, launches the engine, waits for completion and writes the result.
module dp_job_controller
  import dp_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int RESULT_WIDTH = 16,
  parameter int CNT_WIDTH    = 6,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Command handshake: a job is accepted in a cycle where cmd_valid && cmd_ready.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_src1,
  input  logic [ADDR_WIDTH-1:0]   cmd_src2,
  input  logic [ADDR_WIDTH-1:0]   cmd_dst,
  input  logic [CNT_WIDTH-1:0]    cmd_count,
  input  logic                    abort,
  output logic                    rd_en1,
  output logic                    rd_en2,
  output logic [ADDR_WIDTH-1:0]   rd_addr1,
  output logic [ADDR_WIDTH-1:0]   rd_addr2,
  input  logic [DATA_WIDTH-1:0]   rd_data1,
  input  logic [DATA_WIDTH-1:0]   rd_data2,
  output logic                    eng_start,
  output logic [DATA_WIDTH-1:0]   eng_a,
  output logic [DATA_WIDTH-1:0]   eng_b,
  input  logic                    eng_done,
  input  logic [RESULT_WIDTH-1:0] eng_result,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy,
  output logic                    job_done,
  output logic [1:0]              job_err,
  output logic [CNT_WIDTH-1:0]    elems_done,
  output logic [2:0]              dbg_state
);

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_src1, r_src2, r_dst;
  logic [CNT_WIDTH-1:0]    r_count, r_idx, r_elems;
  logic [DATA_WIDTH-1:0]   r_eng_a, r_eng_b;
  logic [RESULT_WIDTH-1:0] r_result;
  logic [1:0]              r_err, w_err_nxt;
  logic                    w_accept, w_last, w_wd_clear, w_wd_en, w_wd_expired;

  assign w_last = (r_idx + CNT_WIDTH'(1)) == r_count;

  dp_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_wd_clear),
    .i_en      (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_err   <= ERR_OK;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_accept    = 1'b0;
    w_wd_clear  = 1'b0;
    w_wd_en     = 1'b0;
    cmd_ready   = 1'b0;
    rd_en1      = 1'b0;
    rd_en2      = 1'b0;
    eng_start   = 1'b0;
    wr_en       = 1'b0;
    job_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_err_nxt   = ERR_OK;
          w_state_nxt = (cmd_count == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        rd_en1      = 1'b1;
        rd_en2      = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD:  w_state_nxt = S_START;
      S_START: begin
        eng_start   = 1'b1;
        w_wd_clear  = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_wd_en = 1'b1;
        if (w_wd_expired) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = S_DONE;
        end else if (eng_done) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        wr_en       = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_READ;
      end
      S_DONE: begin
        job_done    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides every in-job transition; a write in flight this cycle still lands.
    if (abort && (r_state inside {S_READ, S_LOAD, S_START, S_WAIT, S_WRITE})) begin
      w_err_nxt   = ERR_ABORT;
      w_state_nxt = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src1   <= '0;
      r_src2   <= '0;
      r_dst    <= '0;
      r_count  <= '0;
      r_idx    <= '0;
      r_elems  <= '0;
      r_eng_a  <= '0;
      r_eng_b  <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_src1  <= cmd_src1;
        r_src2  <= cmd_src2;
        r_dst   <= cmd_dst;
        r_count <= cmd_count;
        r_idx   <= '0;
        r_elems <= '0;
      end
      if (r_state == S_LOAD) begin
        r_eng_a <= rd_data1;
        r_eng_b <= rd_data2;
      end
      if ((r_state == S_WAIT) && eng_done) begin
        r_result <= eng_result;
      end
      if (r_state == S_WRITE) begin
        r_elems <= r_elems + CNT_WIDTH'(1);
        if (!w_last) r_idx <= r_idx + CNT_WIDTH'(1);
      end
    end
  end

  // Addresses wrap naturally modulo 2^ADDR_WIDTH.
  assign rd_addr1   = r_src1 + r_idx[ADDR_WIDTH-1:0];
  assign rd_addr2   = r_src2 + r_idx[ADDR_WIDTH-1:0];
  assign wr_addr    = r_dst + r_idx[ADDR_WIDTH-1:0];
  assign wr_data    = DATA_WIDTH'(r_result);
  assign eng_a      = r_eng_a;
  assign eng_b      = r_eng_b;
  assign busy       = (r_state != S_IDLE);
  assign job_err    = r_err;
  assign elems_done = r_elems;
  assign dbg_state  = r_state;

endmodule
